ct_lsu_snoop_ctcq_issue: RTL and testbench
==========================================

# ct_lsu_snoop_ctcq_issue

Issue and response stage downstream of the snoop CTC queue entries. It arbitrates among entries that have a pending invalidate request (`pe_req`) and drives one icache or TLB invalidate request at a time. It waits for the invalidate-done handshake and returns a one-hot completion pulse to the owning entry. Independently, it presents completed entries to the BIU response channel and pulses the entry's `inv_en` on each response grant, so the entry can retire.

## Interface
- `ENTRY_NUM`, default 2: number of CTCQ entries, 2..8.
- `cpurst_b`  in  1  async active-low reset.
- `ctcqctrlclk`  in  1  clock.
- `ctcq_pe_req`  in  ENTRY_NUM  per-entry pending invalidate request.
- `ctcq_icache_all_inv`, `ctcq_icache_line_inv`, `ctcq_tlb_all_inv`, `ctcq_tlb_va_all_inv`, `ctcq_tlb_asid_all_inv`, `ctcq_tlb_va_asid_inv`  in  ENTRY_NUM each  per-entry decoded type.
- `ctcq_icache_index`  in  6*ENTRY_NUM  flattened; entry i at [6i+5:6i].
- `ctcq_icache_ptag`  in  28*ENTRY_NUM  flattened.
- `ctcq_tlb_asid`  in  16*ENTRY_NUM  flattened.
- `ctcq_tlb_va`  in  27*ENTRY_NUM  flattened.
- `ctcq_cmplt`  in  ENTRY_NUM  per-entry completion pending (`cmplt_x`).
- `ctcq_2_cmplt`  in  ENTRY_NUM  per-entry two responses remaining.
- `lsu_icache_inv_req`  out  1  icache invalidate request, held until done.
- `lsu_icache_inv_all`  out  1  1 = invalidate all, 0 = invalidate line.
- `lsu_icache_inv_index`  out  6  line index.
- `lsu_icache_inv_ptag`  out  28  line ptag.
- `icache_lsu_inv_done`  in  1  single-cycle done pulse.
- `lsu_mmu_tlbi_req`  out  1  TLB invalidate request, held until done.
- `lsu_mmu_tlbi_type`  out  2  00 all, 01 va_all, 10 asid_all, 11 va_asid.
- `lsu_mmu_tlbi_asid`  out  16  ASID.
- `lsu_mmu_tlbi_va`  out  27  VA.
- `mmu_lsu_tlbi_done`  in  1  single-cycle done pulse.
- `ica_tlb_ctcq_inv_cmplt`  out  ENTRY_NUM  one-hot completion pulse to entry.
- `lsu_biu_ctc_resp_vld`  out  1  response request.
- `lsu_biu_ctc_resp_last`  out  1  last response of the entry.
- `biu_lsu_ctc_resp_grnt`  in  1  response accepted this cycle.
- `ctcq_inv_en`  out  ENTRY_NUM  one-hot, pulses on grant.

## Operation
- Issue FSM states: IDLE, ICREQ, TLBREQ, CMPLT.
- IDLE: if any `ctcq_pe_req` is set, arbitrate one entry. Latch its index and all of its fields into registers.
  - Go to ICREQ if the entry's type is icache_all or icache_line.
  - Go to TLBREQ if the type is any TLB type.
  - If the entry has no type bit set, go to CMPLT directly.
- ICREQ: `lsu_icache_inv_req`=1 with the latched fields. On `icache_lsu_inv_done`, go to CMPLT.
- TLBREQ: `lsu_mmu_tlbi_req`=1 with the latched fields. On `mmu_lsu_tlbi_done`, go to CMPLT.
- Done pulses arriving outside the matching state are ignored.
- CMPLT: `ica_tlb_ctcq_inv_cmplt[idx]`=1 for exactly one cycle, then go to IDLE.
  - The entry's `pe_req` is low by the following IDLE cycle, so the same entry is never re-issued.
- Request data outputs are zero whenever the corresponding req is 0.
- Response path runs concurrently with the issue FSM and is combinational:
  - `resp_vld` = |`ctcq_cmplt`.
  - The selected entry is the lowest index with `ctcq_cmplt` set.
  - `resp_last` = !`ctcq_2_cmplt[sel]`.
  - `ctcq_inv_en[sel]` = `biu_lsu_ctc_resp_grnt` && `resp_vld`.
  - A two-transaction entry (cmplt=2) therefore needs two grants to retire.
- Reset: FSM goes to IDLE and all latched fields clear to 0. All req, cmplt and inv_en outputs are 0. The RR pointer resets to 0.
- Reset mid-request drops the req asynchronously. A late done pulse after reset is ignored.

## Timing
- `pe_req` sampled in IDLE at cycle 0 → req asserted at cycle 1.
- Done at cycle k → cmplt pulse at cycle k+1 → FSM in IDLE at cycle k+2.
- Minimum turnaround per entry is 3 cycles, when done arrives in cycle 1.
- Entry `cmplt_x` rises at cycle k+2; `resp_vld` is high in the same cycle.
- Grant and `inv_en` are in the same cycle.
- Issue and response are independent: a CMPLT pulse and an `inv_en` pulse for different entries may occur in the same cycle.

## Configuration
- `LSU_CTCQ_ISSUE_RR_EN` defined: round-robin issue arbitration.
  - Search starts at the pointer.
  - The pointer moves to the granted index + 1 (mod ENTRY_NUM) on each IDLE grant.
- Undefined: fixed priority, lowest index wins. No pointer register.

## Test plan
- Entry0 `pe_req`, `icache_line_inv`, index=0x2A, ptag=0xABCDEF0 → `lsu_icache_inv_req`=1 next cycle with those values; done at cycle 4 → `inv_cmplt`=0b01 at cycle 5 → IDLE.
- Entry1 `tlb_va_asid_inv`, asid=0x0055, va=0x1234567 → `tlbi_req`=1, `type`=11; done → `inv_cmplt`=0b10.
- Both entries pending with RR_EN: grants alternate 0,1,0. Without RR_EN: entry0 is always granted first.
- `ctcq_cmplt`=0b01, `2_cmplt`=0b01 → `resp_vld`=1, `last`=0; after grant, entry cmplt drops to 1 → `last`=1; second grant → `inv_en`=0b01 on each grant.
- `cpurst_b` asserted during TLBREQ → `tlbi_req`=0 immediately; done pulse after release → no `inv_cmplt`.

Source files
------------

// File: rtl/ct_lsu_snoop_ctcq_issue_if.sv
// Bundle between the snoop CTCQ entries, the icache/MMU invalidate ports and the BIU
// response channel; master is the issue stage, slave is everything around it.
interface ct_lsu_snoop_ctcq_issue_if #(
  parameter int unsigned ENTRY_NUM = 2
);
  logic [ENTRY_NUM-1:0]    ctcq_pe_req;
  logic [ENTRY_NUM-1:0]    ctcq_icache_all_inv;
  logic [ENTRY_NUM-1:0]    ctcq_icache_line_inv;
  logic [ENTRY_NUM-1:0]    ctcq_tlb_all_inv;
  logic [ENTRY_NUM-1:0]    ctcq_tlb_va_all_inv;
  logic [ENTRY_NUM-1:0]    ctcq_tlb_asid_all_inv;
  logic [ENTRY_NUM-1:0]    ctcq_tlb_va_asid_inv;
  logic [6*ENTRY_NUM-1:0]  ctcq_icache_index;
  logic [28*ENTRY_NUM-1:0] ctcq_icache_ptag;
  logic [16*ENTRY_NUM-1:0] ctcq_tlb_asid;
  logic [27*ENTRY_NUM-1:0] ctcq_tlb_va;
  logic [ENTRY_NUM-1:0]    ctcq_cmplt;
  logic [ENTRY_NUM-1:0]    ctcq_2_cmplt;

  logic                    lsu_icache_inv_req;
  logic                    lsu_icache_inv_all;
  logic [5:0]              lsu_icache_inv_index;
  logic [27:0]             lsu_icache_inv_ptag;
  logic                    icache_lsu_inv_done;

  logic                    lsu_mmu_tlbi_req;
  logic [1:0]              lsu_mmu_tlbi_type;
  logic [15:0]             lsu_mmu_tlbi_asid;
  logic [26:0]             lsu_mmu_tlbi_va;
  logic                    mmu_lsu_tlbi_done;

  logic [ENTRY_NUM-1:0]    ica_tlb_ctcq_inv_cmplt;
  logic                    lsu_biu_ctc_resp_vld;
  logic                    lsu_biu_ctc_resp_last;
  logic                    biu_lsu_ctc_resp_grnt;
  logic [ENTRY_NUM-1:0]    ctcq_inv_en;

  modport master (
    input  ctcq_pe_req, ctcq_icache_all_inv, ctcq_icache_line_inv, ctcq_tlb_all_inv,
           ctcq_tlb_va_all_inv, ctcq_tlb_asid_all_inv, ctcq_tlb_va_asid_inv,
           ctcq_icache_index, ctcq_icache_ptag, ctcq_tlb_asid, ctcq_tlb_va,
           ctcq_cmplt, ctcq_2_cmplt, icache_lsu_inv_done, mmu_lsu_tlbi_done,
           biu_lsu_ctc_resp_grnt,
    output lsu_icache_inv_req, lsu_icache_inv_all, lsu_icache_inv_index, lsu_icache_inv_ptag,
           lsu_mmu_tlbi_req, lsu_mmu_tlbi_type, lsu_mmu_tlbi_asid, lsu_mmu_tlbi_va,
           ica_tlb_ctcq_inv_cmplt, lsu_biu_ctc_resp_vld, lsu_biu_ctc_resp_last, ctcq_inv_en
  );

  modport slave (
    output ctcq_pe_req, ctcq_icache_all_inv, ctcq_icache_line_inv, ctcq_tlb_all_inv,
           ctcq_tlb_va_all_inv, ctcq_tlb_asid_all_inv, ctcq_tlb_va_asid_inv,
           ctcq_icache_index, ctcq_icache_ptag, ctcq_tlb_asid, ctcq_tlb_va,
           ctcq_cmplt, ctcq_2_cmplt, icache_lsu_inv_done, mmu_lsu_tlbi_done,
           biu_lsu_ctc_resp_grnt,
    input  lsu_icache_inv_req, lsu_icache_inv_all, lsu_icache_inv_index, lsu_icache_inv_ptag,
           lsu_mmu_tlbi_req, lsu_mmu_tlbi_type, lsu_mmu_tlbi_asid, lsu_mmu_tlbi_va,
           ica_tlb_ctcq_inv_cmplt, lsu_biu_ctc_resp_vld, lsu_biu_ctc_resp_last, ctcq_inv_en
  );
endinterface

// File: rtl/ct_lsu_snoop_ctcq_issue.sv
// Snoop CTCQ issue/response stage: one icache/TLB invalidate in flight, completion pulse back
// to the entry, BIU responses in parallel. Define LSU_CTCQ_ISSUE_RR_EN for round-robin issue.
module ct_lsu_snoop_ctcq_issue #(
  parameter int unsigned ENTRY_NUM = 2
) (
  input logic                       cpurst_b,
  input logic                       ctcqctrlclk,
  ct_lsu_snoop_ctcq_issue_if.master bus
);
  localparam int unsigned IDX_W = $clog2(ENTRY_NUM);
  localparam logic [ENTRY_NUM-1:0] ONE_HOT0 = ENTRY_NUM'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ICREQ = 2'd1, TLBREQ = 2'd2, CMPLT = 2'd3} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ENTRY_NUM-1:0] pe_rot;
  logic [IDX_W-1:0]     pick_off;
  logic [IDX_W-1:0]     gnt_idx;
  logic                 gnt_vld;
  logic                 load;
  logic                 is_ic;
  logic                 is_tlb;
  logic [1:0]           tlb_type_sel;
  logic [IDX_W-1:0]     idx_q;
  logic                 ic_all_q;
  logic [5:0]           ic_index_q;
  logic [27:0]          ic_ptag_q;
  logic [1:0]           tlb_type_q;
  logic [15:0]          tlb_asid_q;
  logic [26:0]          tlb_va_q;
  logic [IDX_W-1:0]     resp_sel;

  assign gnt_vld = |bus.ctcq_pe_req;
  assign load    = (state == IDLE) && gnt_vld;

  // Lowest set bit of the search vector, as an offset from the search start
  always_comb begin
    pick_off = '0;
    for (int i = int'(ENTRY_NUM) - 1; i >= 0; i--)
      if (pe_rot[i]) pick_off = IDX_W'(i);
  end

`ifdef LSU_CTCQ_ISSUE_RR_EN
  localparam logic [IDX_W:0] ENTRY_NUM_W = (IDX_W+1)'(ENTRY_NUM);
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W:0]   gnt_sum;

  assign pe_rot  = ENTRY_NUM'({bus.ctcq_pe_req, bus.ctcq_pe_req} >> rr_ptr);
  assign gnt_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
  assign gnt_idx = (gnt_sum >= ENTRY_NUM_W) ? IDX_W'(gnt_sum - ENTRY_NUM_W) : IDX_W'(gnt_sum);

  // Pointer moves past the entry just granted
  always_ff @(posedge ctcqctrlclk or negedge cpurst_b) begin
    if (!cpurst_b)
      rr_ptr <= '0;
    else if (load)
      rr_ptr <= (gnt_idx == IDX_W'(ENTRY_NUM - 1)) ? '0 : gnt_idx + IDX_W'(1);
  end
`else
  assign pe_rot  = bus.ctcq_pe_req;
  assign gnt_idx = pick_off;
`endif

  // Decode the granted entry's invalidate type
  always_comb begin
    is_ic  = bus.ctcq_icache_all_inv[gnt_idx] | bus.ctcq_icache_line_inv[gnt_idx];
    is_tlb = bus.ctcq_tlb_all_inv[gnt_idx] | bus.ctcq_tlb_va_all_inv[gnt_idx] |
             bus.ctcq_tlb_asid_all_inv[gnt_idx] | bus.ctcq_tlb_va_asid_inv[gnt_idx];
    if (bus.ctcq_tlb_all_inv[gnt_idx])           tlb_type_sel = 2'b00;
    else if (bus.ctcq_tlb_va_all_inv[gnt_idx])   tlb_type_sel = 2'b01;
    else if (bus.ctcq_tlb_asid_all_inv[gnt_idx]) tlb_type_sel = 2'b10;
    else                                         tlb_type_sel = 2'b11;
  end

  always_ff @(posedge ctcqctrlclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      idx_q      <= '0;
      ic_all_q   <= 1'b0;
      ic_index_q <= '0;
      ic_ptag_q  <= '0;
      tlb_type_q <= '0;
      tlb_asid_q <= '0;
      tlb_va_q   <= '0;
    end else if (load) begin
      idx_q      <= gnt_idx;
      ic_all_q   <= bus.ctcq_icache_all_inv[gnt_idx];
      ic_index_q <= bus.ctcq_icache_index[6*gnt_idx +: 6];
      ic_ptag_q  <= bus.ctcq_icache_ptag[28*gnt_idx +: 28];
      tlb_type_q <= tlb_type_sel;
      tlb_asid_q <= bus.ctcq_tlb_asid[16*gnt_idx +: 16];
      tlb_va_q   <= bus.ctcq_tlb_va[27*gnt_idx +: 27];
    end
  end

  always_ff @(posedge ctcqctrlclk or negedge cpurst_b) begin
    if (!cpurst_b) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_vld) state_nxt = is_ic ? ICREQ : (is_tlb ? TLBREQ : CMPLT);
      ICREQ:   if (bus.icache_lsu_inv_done) state_nxt = CMPLT;
      TLBREQ:  if (bus.mmu_lsu_tlbi_done) state_nxt = CMPLT;
      CMPLT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request data is only driven while its request is up
  always_comb begin
    bus.lsu_icache_inv_req     = 1'b0;
    bus.lsu_icache_inv_all     = 1'b0;
    bus.lsu_icache_inv_index   = '0;
    bus.lsu_icache_inv_ptag    = '0;
    bus.lsu_mmu_tlbi_req       = 1'b0;
    bus.lsu_mmu_tlbi_type      = '0;
    bus.lsu_mmu_tlbi_asid      = '0;
    bus.lsu_mmu_tlbi_va        = '0;
    bus.ica_tlb_ctcq_inv_cmplt = '0;
    case (state)
      ICREQ: begin
        bus.lsu_icache_inv_req   = 1'b1;
        bus.lsu_icache_inv_all   = ic_all_q;
        bus.lsu_icache_inv_index = ic_index_q;
        bus.lsu_icache_inv_ptag  = ic_ptag_q;
      end
      TLBREQ: begin
        bus.lsu_mmu_tlbi_req  = 1'b1;
        bus.lsu_mmu_tlbi_type = tlb_type_q;
        bus.lsu_mmu_tlbi_asid = tlb_asid_q;
        bus.lsu_mmu_tlbi_va   = tlb_va_q;
      end
      CMPLT:   bus.ica_tlb_ctcq_inv_cmplt = ONE_HOT0 << idx_q;
      default: ;
    endcase
  end

  // Response channel serves the lowest completed entry
  always_comb begin
    resp_sel = '0;
    for (int i = int'(ENTRY_NUM) - 1; i >= 0; i--)
      if (bus.ctcq_cmplt[i]) resp_sel = IDX_W'(i);
  end

  assign bus.lsu_biu_ctc_resp_vld  = |bus.ctcq_cmplt;
  assign bus.lsu_biu_ctc_resp_last = bus.lsu_biu_ctc_resp_vld & ~bus.ctcq_2_cmplt[resp_sel];
  assign bus.ctcq_inv_en = (bus.biu_lsu_ctc_resp_grnt && bus.lsu_biu_ctc_resp_vld) ?
                           (ONE_HOT0 << resp_sel) : '0;
endmodule

// File: tb/tb_ct_lsu_snoop_ctcq_issue.sv
// Scoreboard bench for ct_lsu_snoop_ctcq_issue: expected requests/completions are queued at
// issue and checked as the DUT produces them; response path and reset are checked directly.
module tb_ct_lsu_snoop_ctcq_issue;
  localparam int unsigned N = 2;

  typedef struct packed {
    logic        ic;
    logic        ic_all;
    logic [5:0]  idx;
    logic [27:0] ptag;
    logic        tlb;
    logic [1:0]  typ;
    logic [15:0] asid;
    logic [26:0] va;
  } exp_req_t;

  typedef struct {
    logic [N-1:0] vec;
    int           cyc;
  } exp_cmplt_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  int          kind [N];
  logic [5:0]  ent_idx [N];
  logic [27:0] ent_ptag [N];
  logic [15:0] ent_asid [N];
  logic [26:0] ent_va [N];
  int          raise_cnt [N];
  int          retire_cnt [N];

  int   ic_lat = 0;
  int   tlb_lat = 0;
  int   ic_cnt = 0;
  int   tlb_cnt = 0;
  logic ic_done_auto = 1'b0;
  logic ic_done_man = 1'b0;
  logic tlb_done_auto = 1'b0;
  logic tlb_done_man = 1'b0;
  logic ic_prev = 1'b0;
  logic tlb_prev = 1'b0;

  exp_req_t   exp_req_q [$];
  exp_cmplt_t exp_cmplt_q [$];

  ct_lsu_snoop_ctcq_issue_if #(.ENTRY_NUM(N)) bus ();

  ct_lsu_snoop_ctcq_issue #(.ENTRY_NUM(N)) dut (
    .cpurst_b   (rst_n),
    .ctcqctrlclk(clk),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int e = 0; e < int'(N); e++) bus.ctcq_pe_req[e] = (raise_cnt[e] != retire_cnt[e]);
  end
  assign bus.icache_lsu_inv_done = ic_done_auto | ic_done_man;
  assign bus.mmu_lsu_tlbi_done   = tlb_done_auto | tlb_done_man;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic exp_req_t model_req(input int e);
    exp_req_t r;
    r        = '0;
    r.ic     = (kind[e] == 1) || (kind[e] == 2);
    r.ic_all = (kind[e] == 1);
    r.tlb    = (kind[e] >= 3);
    r.typ    = r.tlb ? 2'(kind[e] - 3) : 2'b00;
    r.idx    = ent_idx[e];
    r.ptag   = ent_ptag[e];
    r.asid   = ent_asid[e];
    r.va     = ent_va[e];
    return r;
  endfunction

  // kind: 0 none, 1 ic_all, 2 ic_line, 3 tlb_all, 4 va_all, 5 asid_all, 6 va_asid
  task automatic set_entry(input int e, input int k, input logic [5:0] idx, input logic [27:0] ptag,
                           input logic [15:0] asid, input logic [26:0] va);
    kind[e] = k; ent_idx[e] = idx; ent_ptag[e] = ptag; ent_asid[e] = asid; ent_va[e] = va;
    bus.ctcq_icache_all_inv[e]   = (k == 1);
    bus.ctcq_icache_line_inv[e]  = (k == 2);
    bus.ctcq_tlb_all_inv[e]      = (k == 3);
    bus.ctcq_tlb_va_all_inv[e]   = (k == 4);
    bus.ctcq_tlb_asid_all_inv[e] = (k == 5);
    bus.ctcq_tlb_va_asid_inv[e]  = (k == 6);
    bus.ctcq_icache_index[6*e +: 6] = idx;
    bus.ctcq_icache_ptag[28*e +: 28] = ptag;
    bus.ctcq_tlb_asid[16*e +: 16] = asid;
    bus.ctcq_tlb_va[27*e +: 27] = va;
  endtask

  task automatic push_exp(input int e, input int lat, input bit want_cmplt);
    exp_cmplt_t c;
    if (kind[e] != 0) exp_req_q.push_back(model_req(e));
    if (want_cmplt) begin
      c.vec = N'(1) << e;
      c.cyc = (lat < 0) ? -1 : cyc + lat;
      exp_cmplt_q.push_back(c);
    end
  endtask

  task automatic issue(input int e, input int lat, input bit want_cmplt);
    push_exp(e, lat, want_cmplt);
    raise_cnt[e]++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_req_q.size() != 0 || exp_cmplt_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_cmplt_q.size()), 64'd0);
    @(negedge clk);
    check("idle_req", 64'({bus.lsu_icache_inv_req, bus.lsu_mmu_tlbi_req}), 64'd0);
  endtask

  // Done responders: pulse done once the request has been up for the set latency
  always @(negedge clk) begin
    if (ic_lat != 0 && bus.lsu_icache_inv_req) ic_cnt = ic_cnt + 1;
    else ic_cnt = 0;
    ic_done_auto = (ic_lat != 0) && bus.lsu_icache_inv_req && (ic_cnt == ic_lat);
    if (tlb_lat != 0 && bus.lsu_mmu_tlbi_req) tlb_cnt = tlb_cnt + 1;
    else tlb_cnt = 0;
    tlb_done_auto = (tlb_lat != 0) && bus.lsu_mmu_tlbi_req && (tlb_cnt == tlb_lat);
  end

  // Monitor: compare new requests and completion pulses against the scoreboard
  always @(negedge clk) begin
    exp_req_t   r;
    exp_cmplt_t c;
    if (rst_n) begin
      if ((bus.lsu_icache_inv_req && !ic_prev) || (bus.lsu_mmu_tlbi_req && !tlb_prev)) begin
        if (exp_req_q.size() == 0)
          check("req_unexp", 64'({bus.lsu_icache_inv_req, bus.lsu_mmu_tlbi_req}), 64'd0);
        else begin
          r = exp_req_q.pop_front();
          check("req_kind", 64'({bus.lsu_icache_inv_req, bus.lsu_mmu_tlbi_req}), 64'({r.ic, r.tlb}));
          check("ic_data", 64'({bus.lsu_icache_inv_all, bus.lsu_icache_inv_index, bus.lsu_icache_inv_ptag}),
                r.ic ? 64'({r.ic_all, r.idx, r.ptag}) : 64'd0);
          check("tlb_data", 64'({bus.lsu_mmu_tlbi_type, bus.lsu_mmu_tlbi_asid, bus.lsu_mmu_tlbi_va}),
                r.tlb ? 64'({r.typ, r.asid, r.va}) : 64'd0);
        end
      end
      if (bus.ica_tlb_ctcq_inv_cmplt != '0) begin
        if (exp_cmplt_q.size() == 0)
          check("cmplt_unexp", 64'(bus.ica_tlb_ctcq_inv_cmplt), 64'd0);
        else begin
          c = exp_cmplt_q.pop_front();
          check("cmplt_vec", 64'(bus.ica_tlb_ctcq_inv_cmplt), 64'(c.vec));
          if (c.cyc >= 0) check("cmplt_cyc", 64'(cyc), 64'(c.cyc));
        end
        for (int e = 0; e < int'(N); e++)
          if (bus.ica_tlb_ctcq_inv_cmplt[e]) retire_cnt[e]++;
      end
    end
    ic_prev  = bus.lsu_icache_inv_req;
    tlb_prev = bus.lsu_mmu_tlbi_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit reraised;
    for (int e = 0; e < int'(N); e++) begin
      raise_cnt[e] = 0; retire_cnt[e] = 0;
      set_entry(e, 0, '0, '0, '0, '0);
    end
    bus.ctcq_cmplt = '0;
    bus.ctcq_2_cmplt = '0;
    bus.biu_lsu_ctc_resp_grnt = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_req", 64'({bus.lsu_icache_inv_req, bus.lsu_mmu_tlbi_req}), 64'd0);
    check("rst_cmplt", 64'(bus.ica_tlb_ctcq_inv_cmplt), 64'd0);
    check("rst_ic_data", 64'({bus.lsu_icache_inv_all, bus.lsu_icache_inv_index, bus.lsu_icache_inv_ptag}), 64'd0);
    check("rst_tlb_data", 64'({bus.lsu_mmu_tlbi_type, bus.lsu_mmu_tlbi_asid, bus.lsu_mmu_tlbi_va}), 64'd0);
    check("rst_inv_en", 64'(bus.ctcq_inv_en), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // icache line invalidate, done at cycle 4 -> completion at cycle 5
    ic_lat = 4; tlb_lat = 3;
    set_entry(0, 2, 6'h2A, 28'hABCDEF0, 16'h0, 27'h0);
    issue(0, 5, 1'b1);
    drain(40);

    // TLB va+asid; a stray icache done during TLBREQ must be ignored
    ic_lat = 0;
    set_entry(1, 6, 6'h0, 28'h0, 16'h0055, 27'h1234567);
    issue(1, 4, 1'b1);
    @(negedge clk); ic_done_man = 1'b1;
    @(negedge clk); ic_done_man = 1'b0;
    drain(40);

    // Entry with no type bit completes directly
    set_entry(1, 0, 6'h3F, 28'h0, 16'h0, 27'h0);
    issue(1, 1, 1'b1);
    drain(20);

    // Both pending, entry0 re-raised after its first completion
    ic_lat = 1; tlb_lat = 2;
    set_entry(0, 1, 6'h15, 28'h1111111, 16'h0, 27'h0);
    set_entry(1, 3, 6'h0, 28'h0, 16'hBEEF, 27'h7654321);
`ifdef LSU_CTCQ_ISSUE_RR_EN
    push_exp(0, -1, 1'b1); push_exp(1, -1, 1'b1); push_exp(0, -1, 1'b1);
`else
    push_exp(0, -1, 1'b1); push_exp(0, -1, 1'b1); push_exp(1, -1, 1'b1);
`endif
    raise_cnt[0]++; raise_cnt[1]++;
    reraised = 1'b0;
    for (int n = 0; n < 80 && exp_cmplt_q.size() != 0; n++) begin
      @(negedge clk);
      if (!reraised && bus.ica_tlb_ctcq_inv_cmplt[0]) begin
        @(negedge clk);
        raise_cnt[0]++;
        reraised = 1'b1;
      end
    end
    drain(40);
    check("arb_pe_clear", 64'(bus.ctcq_pe_req), 64'd0);

    // Response path: two-response entry then lowest-index selection
    bus.ctcq_cmplt = 2'b01; bus.ctcq_2_cmplt = 2'b01; bus.biu_lsu_ctc_resp_grnt = 1'b0;
    #1;
    check("resp_vld", 64'(bus.lsu_biu_ctc_resp_vld), 64'd1);
    check("resp_last_2", 64'(bus.lsu_biu_ctc_resp_last), 64'd0);
    check("inv_en_nogrnt", 64'(bus.ctcq_inv_en), 64'd0);
    bus.biu_lsu_ctc_resp_grnt = 1'b1;
    #1 check("inv_en_grnt1", 64'(bus.ctcq_inv_en), 64'b01);
    @(negedge clk);
    bus.biu_lsu_ctc_resp_grnt = 1'b0; bus.ctcq_2_cmplt = 2'b00;
    #1 check("resp_last_1", 64'(bus.lsu_biu_ctc_resp_last), 64'd1);
    bus.biu_lsu_ctc_resp_grnt = 1'b1;
    #1 check("inv_en_grnt2", 64'(bus.ctcq_inv_en), 64'b01);
    @(negedge clk);
    bus.ctcq_cmplt = 2'b00;
    #1 check("resp_idle", 64'({bus.lsu_biu_ctc_resp_vld, bus.ctcq_inv_en}), 64'd0);
    bus.ctcq_cmplt = 2'b11; bus.ctcq_2_cmplt = 2'b10;
    #1 check("resp_sel_low", 64'({bus.lsu_biu_ctc_resp_last, bus.ctcq_inv_en}), 64'b101);
    bus.ctcq_cmplt = 2'b10;
    #1 check("resp_sel_hi", 64'({bus.lsu_biu_ctc_resp_last, bus.ctcq_inv_en}), 64'b010);
    @(negedge clk);
    bus.ctcq_cmplt = 2'b00; bus.ctcq_2_cmplt = 2'b00; bus.biu_lsu_ctc_resp_grnt = 1'b0;

    // Reset during TLBREQ drops the request; a late done completes nothing
    tlb_lat = 0;
    set_entry(1, 4, 6'h0, 28'h0, 16'h1234, 27'h0ABCDEF);
    issue(1, -1, 1'b0);
    @(negedge clk);
    check("pre_rst_tlbi", 64'(bus.lsu_mmu_tlbi_req), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_drop_req", 64'({bus.lsu_mmu_tlbi_req, bus.lsu_mmu_tlbi_type, bus.lsu_mmu_tlbi_va}), 64'd0);
    raise_cnt[1] = retire_cnt[1];
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); tlb_done_man = 1'b1;
    @(negedge clk); tlb_done_man = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check("late_done_cmplt", 64'(bus.ica_tlb_ctcq_inv_cmplt), 64'd0);
      @(negedge clk);
    end

    check("sb_req_empty", 64'(exp_req_q.size()), 64'd0);
    check("sb_cmplt_empty", 64'(exp_cmplt_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
